// File: rtl/div_issue_ctrl_if.sv
// Handshake bundle between the EXU issue path, the divide control stage,
// the iterative divider and writeback.
interface div_issue_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             op_valid;
   logic             op_ready;
   logic             op_signed;
   logic             op_rem;
   logic             op_word;
   logic [63:0]      op_src1;
   logic [63:0]      op_src2;
   logic [TAG_W-1:0] op_tag;
   logic             flush;
   logic             div_valid;
   logic             div_flush;
   logic             div_w;
   logic [1:0]       div_signed;
   logic [63:0]      div_dividend;
   logic [63:0]      div_divisor;
   logic             div_ready;
   logic             div_out_valid;
   logic [63:0]      div_quotient;
   logic [63:0]      div_remainder;
   logic             res_valid;
   logic             res_ready;
   logic [63:0]      res_data;
   logic [TAG_W-1:0] res_tag;

   modport slave (
      input  op_valid, op_signed, op_rem, op_word,
      input  op_src1, op_src2, op_tag, flush,
      output op_ready,
      output div_valid, div_flush, div_w, div_signed,
      output div_dividend, div_divisor,
      input  div_ready, div_out_valid,
      input  div_quotient, div_remainder,
      output res_valid, res_data, res_tag,
      input  res_ready
   );

   modport master (
      output op_valid, op_signed, op_rem, op_word,
      output op_src1, op_src2, op_tag, flush,
      input  op_ready,
      input  div_valid, div_flush, div_w, div_signed,
      input  div_dividend, div_divisor,
      output div_ready, div_out_valid,
      output div_quotient, div_remainder,
      input  res_valid, res_data, res_tag,
      output res_ready
   );
endinterface

// File: rtl/div_issue_ctrl.sv
// Divide issue control: latches RV64M div/rem ops, short-circuits
// divide-by-zero and signed overflow, drives the divider, holds the result.
module div_issue_ctrl #(
   parameter int TAG_W = 5
) (
   input logic clock,
   input logic reset,
   div_issue_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, HOLD, FLUSH} state_t;

   state_t           state;
   logic [63:0]      src1_q;
   logic [63:0]      src2_q;
   logic             sgn_q;
   logic             rem_q;
   logic             word_q;
   logic             res_valid_q;
   logic [63:0]      res_data_q;
   logic [TAG_W-1:0] res_tag_q;

   logic        accept;
   logic        dz;
   logic        ovf;
   logic [63:0] byp_val;
   logic [63:0] div_sel;

   function automatic logic [63:0] shape(input logic [63:0] v,
                                         input logic w);
      return w ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

   assign bus.op_ready = (state == IDLE) && !bus.flush;
   assign accept       = bus.op_valid && bus.op_ready;

   always_comb begin
      dz  = 1'b0;
      ovf = 1'b0;
      if (bus.op_word) begin
         dz  = bus.op_src2[31:0] == 32'd0;
         ovf = bus.op_signed
            && (bus.op_src2[31:0] == 32'hFFFF_FFFF)
            && (bus.op_src1[31:0] == 32'h8000_0000);
      end else begin
         dz  = bus.op_src2 == 64'd0;
         ovf = bus.op_signed
            && (bus.op_src2 == 64'hFFFF_FFFF_FFFF_FFFF)
            && (bus.op_src1 == 64'h8000_0000_0000_0000);
      end
   end

   // Divide-by-zero takes precedence over overflow.
   always_comb begin
      byp_val = 64'd0;
      if (dz)
         byp_val = bus.op_rem ? bus.op_src1 : 64'hFFFF_FFFF_FFFF_FFFF;
      else
         byp_val = bus.op_rem ? 64'd0 : bus.op_src1;
   end

   assign div_sel = rem_q ? bus.div_remainder : bus.div_quotient;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         src1_q      <= 64'd0;
         src2_q      <= 64'd0;
         sgn_q       <= 1'b0;
         rem_q       <= 1'b0;
         word_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 64'd0;
         res_tag_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  src1_q    <= bus.op_src1;
                  src2_q    <= bus.op_src2;
                  sgn_q     <= bus.op_signed;
                  rem_q     <= bus.op_rem;
                  word_q    <= bus.op_word;
                  res_tag_q <= bus.op_tag;
                  if (dz || ovf) begin
                     res_data_q  <= shape(byp_val, bus.op_word);
                     res_valid_q <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               // A flush beats a same-cycle divider result.
               if (bus.flush) begin
                  state <= FLUSH;
               end else if (bus.div_out_valid) begin
                  res_data_q  <= shape(div_sel, word_q);
                  res_valid_q <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (bus.flush || bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            FLUSH: begin
               if (bus.div_ready)
                  state <= IDLE;
            end
         endcase
      end
   end

   // In FLUSH the divider is clocked with abort until it reports idle.
   assign bus.div_valid = (state == RUN)
                       || ((state == FLUSH) && !bus.div_ready);
   assign bus.div_flush    = state == FLUSH;
   assign bus.div_w        = word_q;
   assign bus.div_signed   = {2{sgn_q}};
   assign bus.div_dividend = src1_q;
   assign bus.div_divisor  = src2_q;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_data     = res_data_q;
   assign bus.res_tag      = res_tag_q;
endmodule
